// File: rtl/odd_parity_frame_tx_pkg.sv
// Shared definitions for the odd-parity serial frame transmitter:
// FSM state encoding, nibble width, counter sizing and the parity helper.
package odd_parity_frame_tx_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Bit-time counter width; never narrower than one bit.
  function automatic int cnt_width(input int clks_per_bit);
    int w;
    w = $clog2(clks_per_bit * 2);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [NIBBLE_W-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/odd_parity_frame_tx_if.sv
// Nibble handshake between a producer (master) and the transmitter (slave).
interface odd_parity_frame_tx_if;

  logic                                         in_valid;
  logic                                         in_ready;
  logic [odd_parity_frame_tx_pkg::NIBBLE_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/odd_parity_generator.sv
// Combinational odd-parity generator for one nibble.
module odd_parity_generator
  import odd_parity_frame_tx_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  output logic                y
);

  assign y = odd_parity(a);

endmodule

// File: rtl/odd_parity_frame_tx.sv
// Serial frame transmitter: start bit, 4 data bits LSB first, odd parity,
// STOP_BITS stop bits. Each bit is held CLKS_PER_BIT clocks. tx and
// frame_done are registered; frame_done is computed from the next state so
// it lands exactly on the final stop-bit cycle.
module odd_parity_frame_tx
  import odd_parity_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  odd_parity_frame_tx_if.slave bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int               CNT_W     = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  state_e                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [1:0]            idx_r, idx_s;
  logic [NIBBLE_W-1:0]   data_r, data_s;
  logic                  parity_r, parity_s;
  logic                  tx_r, tx_s;
  logic                  done_r, done_s;
  logic                  gen_parity_s;
  logic                  wrap_s;

  odd_parity_generator u_parity (
    .a (bus.in_data),
    .y (gen_parity_s)
  );

  assign wrap_s       = (cnt_r == CNT_LAST);
  assign bus.in_ready = (state_r == IDLE) && !rst;
  assign busy         = (state_r != IDLE);
  assign tx           = tx_r;
  assign frame_done   = done_r;

  // Next-state, bit timing and serial line level for the following cycle.
  always_comb begin
    state_s  = state_r;
    cnt_s    = wrap_s ? '0 : cnt_r + CNT_W'(1);
    idx_s    = idx_r;
    data_s   = data_r;
    parity_s = parity_r;
    tx_s     = tx_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        idx_s = 2'd0;
        if (bus.in_valid) begin
          state_s  = START;
          data_s   = bus.in_data;
          parity_s = gen_parity_s;
          tx_s     = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      START: begin
        if (wrap_s) begin
          state_s = DATA;
          idx_s   = 2'd0;
          tx_s    = data_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      DATA: begin
        if (wrap_s) begin
          if (idx_r == 2'd3) begin
            state_s = PARITY;
            idx_s   = 2'd0;
            tx_s    = parity_r;
          end else begin
            idx_s = idx_r + 2'd1;
            tx_s  = data_r[idx_r + 2'd1];
          end
        end else begin
          tx_s = data_r[idx_r];
        end
      end
      PARITY: begin
        if (wrap_s) begin
          state_s = STOP;
          idx_s   = 2'd0;
          tx_s    = 1'b1;
        end else begin
          tx_s = parity_r;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (wrap_s) begin
          if (idx_r == STOP_LAST) begin
            state_s = IDLE;
            idx_s   = 2'd0;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        idx_s   = 2'd0;
        tx_s    = 1'b1;
      end
    endcase
    done_s = (state_s == STOP) && (idx_s == STOP_LAST) && (cnt_s == CNT_LAST);
  end

  // State and output registers; reset forces the line idle and drops any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= 2'd0;
      data_r   <= '0;
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      data_r   <= data_s;
      parity_r <= parity_s;
      tx_r     <= tx_s;
      done_r   <= done_s;
    end
  end

endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// Self-checking bench: a frame-level model predicts tx/busy/frame_done/in_ready
// every cycle for two instances (defaults, and CLKS_PER_BIT=1/STOP_BITS=2),
// plus directed checks with hand-computed literals.
module tb_odd_parity_frame_tx;

  localparam int CPB_A = 4;
  localparam int SB_A  = 1;
  localparam int LEN_A = (6 + SB_A) * CPB_A;
  localparam int CPB_B = 1;
  localparam int SB_B  = 2;
  localparam int LEN_B = (6 + SB_B) * CPB_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_tx, a_busy, a_done;
  logic b_tx, b_busy, b_done;

  int errors = 0;
  int checks = 0;

  odd_parity_frame_tx_if a_if ();
  odd_parity_frame_tx_if b_if ();

  odd_parity_frame_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .tx(a_tx), .busy(a_busy), .frame_done(a_done)
  );

  odd_parity_frame_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave),
    .tx(b_tx), .busy(b_busy), .frame_done(b_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Frame bit b of nibble d: start, d0..d3, odd parity, then stop ones.
  function automatic logic exp_bit(input logic [3:0] d, input int b);
    if (b == 0) return 1'b0;
    else if (b <= 4) return d[b-1];
    else if (b == 5) return ~^d;
    else return 1'b1;
  endfunction

  // Model: position inside the current frame (-1 = idle) and latched nibble.
  int pos_a = -1;
  int pos_b = -1;
  logic [3:0] d_a = 4'h0;
  logic [3:0] d_b = 4'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_a <= -1;
      pos_b <= -1;
    end else begin
      if (pos_a < 0) begin
        if (a_if.in_valid === 1'b1) begin pos_a <= 0; d_a <= a_if.in_data; end
      end else if (pos_a == LEN_A - 1) pos_a <= -1;
      else pos_a <= pos_a + 1;
      if (pos_b < 0) begin
        if (b_if.in_valid === 1'b1) begin pos_b <= 0; d_b <= b_if.in_data; end
      end else if (pos_b == LEN_B - 1) pos_b <= -1;
      else pos_b <= pos_b + 1;
    end
  end

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    chk("a_tx",    int'(a_tx),   int'(pos_a < 0 ? 1'b1 : exp_bit(d_a, pos_a / CPB_A)));
    chk("a_busy",  int'(a_busy), int'(pos_a >= 0));
    chk("a_done",  int'(a_done), int'(pos_a == LEN_A - 1));
    chk("a_ready", int'(a_if.in_ready), int'(pos_a < 0 && !rst));
    chk("b_tx",    int'(b_tx),   int'(pos_b < 0 ? 1'b1 : exp_bit(d_b, pos_b / CPB_B)));
    chk("b_busy",  int'(b_busy), int'(pos_b >= 0));
    chk("b_done",  int'(b_done), int'(pos_b == LEN_B - 1));
    chk("b_ready", int'(b_if.in_ready), int'(pos_b < 0 && !rst));
  end

  // Called at a negedge; returns just after the handshake posedge.
  task automatic send_a(input logic [3:0] n);
    int t;
    a_if.in_valid = 1'b1;
    a_if.in_data  = n;
    t = 0;
    while (a_if.in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk("a_handshake", int'(a_if.in_ready), 1);
    @(posedge clk);
  endtask

  task automatic send_b(input logic [3:0] n);
    int t;
    b_if.in_valid = 1'b1;
    b_if.in_data  = n;
    t = 0;
    while (b_if.in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk("b_handshake", int'(b_if.in_ready), 1);
    @(posedge clk);
  endtask

  logic [15:0] par_tab = 16'h9669;
  logic [6:0]  obs7;
  logic [4:0]  f1;
  logic [7:0]  obs8, dn8;
  logic        r29, p2;
  int          done_k, viol, idle_cnt, dcount;

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = 4'h0;
    b_if.in_valid = 1'b0; b_if.in_data = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(a_tx), 1);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_ready", int'(a_if.in_ready), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(a_if.in_ready), 1);

    // Idle hold for 100 cycles.
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) viol++;
    end
    chk("idle_hold", viol, 0);

    // Single frame of 4'h5 with default timing.
    send_a(4'h5);
    done_k = 0; obs7 = '0; r29 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) a_if.in_valid = 1'b0;
      if (k % 4 == 2) obs7[(k - 2) / 4] = a_tx;
      if (a_done === 1'b1 && done_k == 0) done_k = k;
      if (k == 29) r29 = a_if.in_ready;
    end
    chk("frame5_bits", int'(obs7), int'(7'b1101010));
    chk("frame5_done_cycle", done_k, 28);
    chk("frame5_ready_29", int'(r29), 1);

    // Parity sweep over all nibbles.
    for (int n = 0; n < 16; n++) begin
      send_a(4'(n));
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (k == 1) a_if.in_valid = 1'b0;
        if (k == 22) chk($sformatf("parity_%0h", n), int'(a_tx), int'(par_tab[n]));
      end
    end

    // Back-to-back: 4'h3 then 4'hC with in_valid held high.
    send_a(4'h3);
    f1 = '0; p2 = 1'b0; idle_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 3) a_if.in_data = 4'hC;
      if (k == 31) a_if.in_valid = 1'b0;
      if (k >= 6 && k <= 22 && (k - 6) % 4 == 0) f1[(k - 6) / 4] = a_tx;
      if (k == 51) p2 = a_tx;
      if (k <= 57 && a_busy === 1'b0) idle_cnt++;
    end
    chk("b2b_frame1_bits", int'(f1), int'(5'b10011));
    chk("b2b_frame2_parity", int'(p2), 1);
    chk("b2b_idle_cycles", idle_cnt, 1);

    // CLKS_PER_BIT=1, STOP_BITS=2, nibble 4'h8.
    @(negedge clk);
    send_b(4'h8);
    obs8 = '0; dn8 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) b_if.in_valid = 1'b0;
      if (k <= 8) begin obs8[k - 1] = b_tx; dn8[k - 1] = b_done; end
    end
    chk("fast_bits", int'(obs8), int'(8'hD0));
    chk("fast_done", int'(dn8), int'(8'h80));

    // Reset during data bit idx=2 of 4'hA.
    send_a(4'hA);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) a_if.in_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", int'(a_tx), 1);
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_ready", int'(a_if.in_ready), 0);
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_done === 1'b1) dcount++;
    end
    #1 rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a_done === 1'b1) dcount++;
    end
    chk("midrst_no_done", dcount, 0);

    send_a(4'h6);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) a_if.in_valid = 1'b0;
      if (k == 22) chk("after_rst_parity6", int'(a_tx), 1);
      if (k == 28) chk("after_rst_done", int'(a_done), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odd_parity_frame_tx.md
Name: odd_parity_frame_tx

Overview:
Serial frame transmitter that sequences the 4-bit odd-parity datapath. It accepts one nibble per valid/ready handshake and computes its odd parity bit. It then serialises the frame on a single line: start bit, 4 data bits LSB first, parity bit, stop bit(s). It sits between a nibble producer and an external serial link and owns all bit timing.

Parameters:
- CLKS_PER_BIT, default 4: clk cycles each serial bit is held; legal range >= 1.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a nibble on in_data.
- in_ready  output  1  block can accept a nibble this cycle.
- in_data  input  4  nibble to transmit.
- tx  output  1  serial line, registered; idle level is 1.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse at the end of each completed frame.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, tx=1, busy=0, frame_done=0, in_ready=1 once rst is low.
  - Bit counter, cycle counter and data register are cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- in_ready=1 only in IDLE (combinational from state). Handshake occurs on the edge where in_valid & in_ready.
- Handshake edge actions:
  - Latch in_data into the shift register.
  - Latch parity = ~(d0^d1^d2^d3).
  - Go to START.
  - tx goes 0 on that same edge, so it is registered and visible the cycle after the handshake.
- Each serial bit is held for exactly CLKS_PER_BIT cycles.
  - The cycle counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
- START: tx=0 for one bit time -> DATA.
- DATA: tx=data[idx] for idx=0..3, LSB first. The 2-bit idx increments on each bit-time wrap. After idx=3 -> PARITY.
- PARITY: tx=latched parity for one bit time -> STOP.
- STOP: tx=1 for STOP_BITS bit times -> IDLE.
  - frame_done=1 for exactly the last clk cycle of the final stop bit.
- Frame length is (6+STOP_BITS)*CLKS_PER_BIT cycles from the first tx=0 cycle through the last stop cycle. With defaults this is 28 cycles.
- Back-to-back frames:
  - in_ready rises on the cycle after frame_done.
  - A waiting in_valid is accepted that cycle, so there is exactly one idle cycle (tx=1) between frames.
- in_data and in_valid changes while busy are ignored; the latched nibble and parity are used.
- in_valid with X data in IDLE is accepted as given; no data checks.
- CLKS_PER_BIT=1: every state lasts one cycle; the counter is effectively constant 0. This must still work.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), state returns to IDLE, and no frame_done pulse is issued. The partial frame is dropped, not resumed.
- busy=1 from the cycle after handshake through the frame_done cycle inclusive.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, START, DATA, PARITY, STOP).
  - Localparam NIBBLE_W=4.
  - Counter width derived as $clog2(CLKS_PER_BIT*2) with a minimum of 1.
- One sub-module is natural: instantiate the existing odd_parity_generator (a[3:0] -> y) on in_data. Its y is registered at handshake; do not re-derive parity inline.

Test Plan:
- Defaults, send 4'h5 once -> tx per bit-time: 0,1,0,1,0,1(parity),1(stop). Each level held 4 cycles; frame_done high on cycle 28 after first tx=0; in_ready high cycle 29.
- Parity sweep, all 16 nibbles, with a check on the parity bit time:
  - 4'h0 -> 1, 4'hF -> 1.
  - 4'h7 -> 0, 4'hB -> 0, 4'h1 -> 0.
  - In general, parity = ~^data.
- in_valid held high with nibbles 4'h3 then 4'hC -> two complete frames with exactly one idle tx=1 cycle between them; the second frame parity=1. Changing in_data mid-frame 1 does not alter frame 1 bits.
- CLKS_PER_BIT=1, STOP_BITS=2, send 4'h8 -> tx sequence 0,0,0,0,1,0,1,1 over 8 cycles; frame_done on the 8th cycle only.
- Assert rst asynchronously during the DATA bit idx=2 of 4'hA:
  - tx=1, busy=0 and in_ready=0 within the same cycle.
  - No frame_done pulse.
  - After release, 4'h6 is sent cleanly with parity=1.
- Idle hold: in_valid=0 for 100 cycles after reset -> tx constantly 1, busy=0, frame_done never asserted.
